// File: rtl/lut_sweep_pkg.sv
// rtl/lut_sweep_pkg.sv - shared state encoding, parameter limits and depth helper for lut_sweep
package lut_sweep_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int K_MIN = 2;
  localparam int K_MAX = 6;
  localparam int C_MIN = 1;
  localparam int C_MAX = 8;

  function automatic int lut_depth(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/lut_sweep_mem.sv
// rtl/lut_sweep_mem.sv - D x C truth-table storage, synchronous write, combinational read
module lut_sweep_mem
  import lut_sweep_pkg::*;
#(
  parameter int K = 4,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [K-1:0] i_waddr,
  input  logic [C-1:0] i_wdata,
  input  logic [K-1:0] i_raddr,
  output logic [C-1:0] o_rdata
);

  localparam int D = lut_depth(K);

  logic [C-1:0] r_table [D];

  // Reads see the pre-edge contents, so a same-cycle write never leaks into the read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_table <= '{default: '0};
    end else if (i_we) begin
      r_table[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_table[i_raddr];

endmodule

// File: rtl/lut_sweep.sv
// rtl/lut_sweep.sv - multi-channel programmable truth-table engine with evaluate and sweep modes
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int K = 4,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [K-1:0] cfg_addr,
  input  logic [C-1:0] cfg_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_bits,
  input  logic         sweep_start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_idx,
  output logic [C-1:0] out_data,
  output logic         out_last
);

  localparam int D  = lut_depth(K);
  localparam int CW = K + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(D - 1);

  generate
    if (K < K_MIN || K > K_MAX) begin : g_bad_k
      $error("lut_sweep: K outside legal range");
    end
    if (C < C_MIN || C > C_MAX) begin : g_bad_c
      $error("lut_sweep: C outside legal range");
    end
  endgenerate

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic [K-1:0]  r_out_idx;
  logic [C-1:0]  r_out_data;
  logic          r_out_last;

  logic          w_idle;
  logic          w_slot_free;
  logic          w_eval_fire;
  logic          w_sweep_load;
  logic          w_mem_we;
  logic [K-1:0]  w_raddr;
  logic [C-1:0]  w_rdata;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_eval_fire  = w_idle && w_slot_free && in_valid;
  assign w_sweep_load = !w_idle && w_slot_free;
  // Table is frozen during a sweep so every beat comes from one consistent snapshot.
  assign w_mem_we     = w_idle && cfg_we;
  assign w_raddr      = w_idle ? in_bits : r_cnt[K-1:0];

  lut_sweep_mem #(
    .K(K),
    .C(C)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_mem_we),
    .i_waddr(cfg_addr),
    .i_wdata(cfg_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_eval_fire) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= in_bits;
            r_out_data  <= w_rdata;
            r_out_last  <= 1'b0;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
          // An eval accepted alongside sweep_start occupies the slot before row 0.
          if (sweep_start) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          if (w_sweep_load) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= r_cnt[K-1:0];
            r_out_data  <= w_rdata;
            r_out_last  <= (r_cnt == LAST_ROW);
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == LAST_ROW) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = w_idle && w_slot_free;
  assign busy      = (r_state == ST_SWEEP);
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_lut_sweep.sv
// tb/tb_lut_sweep.sv - randomized self-checking bench for lut_sweep against a table/queue model
module tb_lut_sweep;

  localparam int K = 4;
  localparam int C = 2;
  localparam int D = 16;

  typedef struct {
    logic [K-1:0] idx;
    logic [C-1:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [K-1:0] cfg_addr = '0;
  logic [C-1:0] cfg_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [K-1:0] in_bits = '0;
  logic         sweep_start = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [K-1:0] out_idx;
  logic [C-1:0] out_data;
  logic         out_last;

  always #5 clk = ~clk;

  lut_sweep #(
    .K(K),
    .C(C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .sweep_start(sweep_start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [C-1:0] tbl [D];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Exercise functions: ch0 = (a&c)|(b&d), ch1 = a^d with a the MSB.
  function automatic logic [C-1:0] golden(input int r);
    logic [3:0] v;
    v = 4'(r);
    return {v[3] ^ v[0], (v[3] & v[1]) | (v[2] & v[0])};
  endfunction

  task automatic do_write(input logic [K-1:0] a, input logic [C-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tbl[a] = d;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_eval(input logic [K-1:0] bits, input bit wr, input logic [K-1:0] wa,
                         input logic [C-1:0] wd, input int stall);
    logic [C-1:0] e;
    e = tbl[bits];
    in_valid = 1'b1; in_bits = bits; out_ready = 1'b1;
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      tbl[wa] = wd;
    end
    #1 chk("eval_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    out_ready = (stall == 0);
    chk("eval_valid", 32'(out_valid), 32'(1));
    chk("eval_idx", 32'(out_idx), 32'(bits));
    chk("eval_data", 32'(out_data), 32'(e));
    chk("eval_last", 32'(out_last), 32'(0));
    chk("eval_busy", 32'(busy), 32'(0));
    for (int s = 0; s < stall; s++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); @(negedge clk);
      chk("eval_hold_valid", 32'(out_valid), 32'(1));
      chk("eval_hold_idx", 32'(out_idx), 32'(bits));
      chk("eval_hold_data", 32'(out_data), 32'(e));
      if (s == stall - 1) out_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk("eval_drop", 32'(out_valid), 32'(0));
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
  task automatic do_sweep(input int mode, input bit inj, input bit with_eval,
                          input logic [K-1:0] ev_bits, input bit with_wr,
                          input logic [K-1:0] wa, input logic [C-1:0] wd);
    beat_t q[$];
    beat_t b;
    beat_t prev;
    bit stalled, seen_last, done, started, rdy;
    int bubbles, cyc, n_beats, row0_cyc;
    logic s_v, s_last;
    logic [K-1:0] s_idx;
    logic [C-1:0] s_data;
    q = {};
    if (with_eval) begin
      q.push_back('{ev_bits, tbl[ev_bits], 1'b0});
      in_valid = 1'b1; in_bits = ev_bits;
    end
    if (with_wr) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      tbl[wa] = wd;
    end
    for (int i = 0; i < D; i++) q.push_back('{4'(i), tbl[i], (i == D - 1)});
    sweep_start = 1'b1; out_ready = 1'b1;
    if (with_eval) #1 chk("sweep_eval_ready", 32'(in_ready), 32'(1));
    @(posedge clk); @(negedge clk);
    sweep_start = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    stalled = 0; seen_last = 0; done = 0; started = 0;
    bubbles = 0; cyc = 0; n_beats = 0; row0_cyc = -1;
    prev = '{'0, '0, 1'b0};
    while (!done && cyc < 200) begin
      s_v = out_valid; s_idx = out_idx; s_data = out_data; s_last = out_last;
      if (s_v && s_last) seen_last = 1;
      chk("sweep_busy", 32'(busy), 32'(!seen_last));
      if (stalled) begin
        chk("hold_valid", 32'(s_v), 32'(1));
        chk("hold_idx", 32'(s_idx), 32'(prev.idx));
        chk("hold_data", 32'(s_data), 32'(prev.data));
        chk("hold_last", 32'(s_last), 32'(prev.last));
      end
      if (started && !s_v) bubbles++;
      if (s_v) started = 1;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (inj && !seen_last) begin
        cfg_we = 1'($urandom_range(0, 1)); cfg_addr = 4'($urandom); cfg_data = 2'($urandom);
        in_valid = 1'($urandom_range(0, 1)); in_bits = 4'($urandom);
      end else begin
        cfg_we = 1'b0; in_valid = 1'b0;
      end
      #1;
      if (!seen_last) chk("sweep_in_ready", 32'(in_ready), 32'(0));
      if (s_v && rdy) begin
        if (n_beats == int'(with_eval)) row0_cyc = cyc;
        if (q.size() == 0) begin
          chk("extra_beat", 32'(s_idx), 32'hFFFF_FFFF);
        end else begin
          b = q.pop_front();
          chk("beat_idx", 32'(s_idx), 32'(b.idx));
          chk("beat_data", 32'(s_data), 32'(b.data));
          chk("beat_last", 32'(s_last), 32'(b.last));
        end
        n_beats++;
        if (s_last) done = 1;
      end
      stalled = s_v && !rdy;
      prev = '{s_idx, s_data, s_last};
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("sweep_done", 32'(done), 32'(1));
    chk("sweep_beats", 32'(n_beats), 32'(D + int'(with_eval)));
    chk("sweep_post_valid", 32'(out_valid), 32'(0));
    chk("sweep_post_busy", 32'(busy), 32'(0));
    if (mode == 0) begin
      chk("sweep_bubbles", 32'(bubbles), 32'(0));
      chk("row0_latency", 32'(row0_cyc), 32'(1));
    end
  endtask

  task automatic do_reset_mid_sweep();
    bit found;
    sweep_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    sweep_start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid && out_idx == 4'd7) found = 1;
      else begin
        @(posedge clk); @(negedge clk);
      end
    end
    chk("rst_reach_idx7", 32'(found), 32'(1));
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) tbl[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) tbl[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_idx", 32'(out_idx), 32'(0));
    chk("reset_data", 32'(out_data), 32'(0));
    chk("reset_last", 32'(out_last), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    do_eval(4'b0101, 0, '0, '0, 0);
    for (int r = 0; r < D; r++) do_write(4'(r), golden(r));
    do_eval(4'b0101, 0, '0, '0, 0);
    do_eval(4'b1010, 0, '0, '0, 2);
    do_sweep(0, 0, 0, '0, 0, '0, '0);
    do_sweep(1, 0, 0, '0, 0, '0, '0);
    do_eval(4'b0101, 1, 4'd5, 2'b10, 0);
    do_eval(4'b0101, 0, '0, '0, 0);
    do_sweep(2, 1, 0, '0, 0, '0, '0);
    do_sweep(0, 0, 0, '0, 0, '0, '0);
    do_sweep(0, 0, 1, 4'd3, 1, 4'd9, 2'b11);
    do_sweep(1, 1, 1, 4'd9, 1, 4'd9, 2'b00);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(4'($urandom), 2'($urandom));
        1: do_eval(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)));
        default: do_sweep(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                          4'($urandom), 2'($urandom));
      endcase
    end

    do_reset_mid_sweep();
    do_eval(4'b1111, 0, '0, '0, 0);
    do_sweep(0, 0, 0, '0, 0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
